mem_bus_decoder: RTL and testbench

Parametrised address decoder and response multiplexer between one picorv32-style native memory master and NSLV slaves (RAM, SDRAM controller, console, etc.). It replaces the fixed combinational region select in the SoC top. The slave is latched per transaction, and unmapped accesses or unresponsive slaves are answered with a bus-error response instead of hanging the core. Error status is exported for debug and simulation monitors.

---
 rtl/mem_bus_decoder.sv | 165 ++++++++++++++++
 tb/tb_mem_bus_decoder.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_decoder.sv
// mem_bus_decoder: routes one native memory master to NSLV slaves by address
// region (mem_addr[31:28]). The selected slave is latched per transaction.
// Unmapped accesses and slaves that never answer get a one-cycle bus-error
// response, so the core cannot hang. The last error is kept for debug.
module mem_bus_decoder #(
  parameter int                 NSLV     = 4,
  parameter logic [NSLV*16-1:0] SLV_MAP  = {16'h0301, 16'h0008, 16'h0200, 16'h0001},
  parameter int                 TIMEOUT  = 1024,
  parameter logic [31:0]        ERR_DATA = 32'hDEADBEEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [31:0]          mem_addr,
  input  logic [31:0]          mem_wdata,
  input  logic [3:0]           mem_wstrb,
  output logic [31:0]          mem_rdata,
  output logic [NSLV-1:0]      s_mem_valid,
  input  logic [NSLV-1:0]      s_mem_ready,
  input  logic [NSLV*32-1:0]   s_mem_rdata,
  output logic [31:0]          s_mem_addr,
  output logic [31:0]          s_mem_wdata,
  output logic [3:0]           s_mem_wstrb,
  output logic                 err_pulse,
  output logic [1:0]           err_code,
  output logic [31:0]          err_addr,
  output logic [15:0]          err_cnt
);

  localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_UNMAPPED = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

  state_t          state_q;
  logic [SW-1:0]   sel_q;
  logic [TW-1:0]   timer_q;
  logic [1:0]      err_code_q;
  logic [31:0]     err_addr_q;
  logic [15:0]     err_cnt_q;
  logic [15:0]     err_cnt_d;

  logic [3:0]      region;
  logic [NSLV-1:0] slv_hit;
  logic            hit;
  logic [SW-1:0]   idx;
  logic [NSLV-1:0] sel_onehot;
  logic            sel_ready;
  logic [31:0]     sel_rdata;

  assign region = mem_addr[31:28];

  // Per-slave region ownership for the current address.
  for (genvar gi = 0; gi < NSLV; gi++) begin : g_hit
    logic [15:0] fld;
    assign fld         = SLV_MAP[16*gi +: 16];
    assign slv_hit[gi] = fld[region];
  end

  // Priority encode: scanning downwards leaves the lowest owning index.
  always_comb begin
    hit = |slv_hit;
    idx = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (slv_hit[i]) idx = SW'(i);
    end
  end

  // One-hot view of the latched selection.
  for (genvar gi = 0; gi < NSLV; gi++) begin : g_sel
    assign sel_onehot[gi] = (sel_q == SW'(gi));
  end

  // Response mux from the latched slave; other slaves' ready is ignored.
  always_comb begin
    sel_ready = |(s_mem_ready & sel_onehot);
    sel_rdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (sel_onehot[i]) sel_rdata = s_mem_rdata[32*i +: 32];
    end
  end

  // Master-side response: passthrough in BUSY, fixed error word in ERR.
  always_comb begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    case (state_q)
      BUSY: begin
        mem_ready = sel_ready;
        mem_rdata = sel_ready ? sel_rdata : 32'h0;
      end
      ERR: begin
        mem_ready = 1'b1;
        mem_rdata = ERR_DATA;
      end
      default: ;
    endcase
  end

  assign s_mem_valid = (state_q == BUSY && mem_valid) ? sel_onehot : '0;

  // Broadcast is combinational but held at zero while reset is asserted.
  assign s_mem_addr  = rst_n ? mem_addr  : 32'h0;
  assign s_mem_wdata = rst_n ? mem_wdata : 32'h0;
  assign s_mem_wstrb = rst_n ? mem_wstrb : 4'h0;

  assign err_pulse = (state_q == ERR);
  assign err_code  = err_code_q;
  assign err_addr  = err_addr_q;
  assign err_cnt   = err_cnt_q;

  assign err_cnt_d = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;

  // Transaction FSM: decode in IDLE, wait/time out in BUSY, one-cycle ERR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      timer_q    <= '0;
      err_code_q <= ERR_NONE;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_valid) begin
            if (hit) begin
              sel_q   <= idx;
              timer_q <= '0;
              state_q <= BUSY;
            end else begin
              err_addr_q <= mem_addr;
              err_code_q <= ERR_UNMAPPED;
              state_q    <= ERR;
            end
          end
        end
        BUSY: begin
          if (!mem_valid) begin
            state_q <= IDLE;
          end else if (sel_ready) begin
            state_q <= IDLE;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            err_addr_q <= mem_addr;
            err_code_q <= ERR_TIMEOUT;
            state_q    <= ERR;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ERR: begin
          err_cnt_q <= err_cnt_d;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_decoder.sv
// Directed bench for mem_bus_decoder with the default region map and a
// short timeout. Inputs change on the falling edge; outputs are checked 1ns
// later, well away from the rising edge.
module tb_mem_bus_decoder;

  logic         clk;
  logic         rst_n;
  logic         mem_valid;
  logic         mem_ready;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [3:0]   mem_wstrb;
  logic [31:0]  mem_rdata;
  logic [3:0]   s_mem_valid;
  logic [3:0]   s_mem_ready;
  logic [127:0] s_mem_rdata;
  logic [31:0]  s_mem_addr;
  logic [31:0]  s_mem_wdata;
  logic [3:0]   s_mem_wstrb;
  logic         err_pulse;
  logic [1:0]   err_code;
  logic [31:0]  err_addr;
  logic [15:0]  err_cnt;

  int passed = 0;
  int total  = 0;

  mem_bus_decoder #(
    .NSLV    (4),
    .SLV_MAP ({16'h0301, 16'h0008, 16'h0200, 16'h0001}),
    .TIMEOUT (16),
    .ERR_DATA(32'hDEADBEEF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rdata  (mem_rdata),
    .s_mem_valid(s_mem_valid),
    .s_mem_ready(s_mem_ready),
    .s_mem_rdata(s_mem_rdata),
    .s_mem_addr (s_mem_addr),
    .s_mem_wdata(s_mem_wdata),
    .s_mem_wstrb(s_mem_wstrb),
    .err_pulse  (err_pulse),
    .err_code   (err_code),
    .err_addr   (err_addr),
    .err_cnt    (err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one mapped access: a decode cycle, then lat BUSY cycles with the
  // expected slave answering on the last one.
  task automatic run_mapped(input string name, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [3:0] ws,
                            input int lat, input logic [3:0] exp_sel,
                            input logic [31:0] exp_rd);
    logic       exp_rdy;
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = addr; mem_wdata = wd; mem_wstrb = ws;
    s_mem_ready = 4'b0000;
    #1;
    total++;
    if (s_mem_valid !== 4'b0000 || mem_ready !== 1'b0)
      $display("FAIL %s_decode: s_mem_valid=%b mem_ready=%b, want 0000/0", name, s_mem_valid, mem_ready);
    else passed++;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      exp_rdy = (k == lat);
      s_mem_ready = exp_rdy ? exp_sel : 4'b0000;
      #1;
      total++;
      if (s_mem_valid !== exp_sel)
        $display("FAIL %s_sel c%0d: s_mem_valid=%b want %b", name, k, s_mem_valid, exp_sel);
      else passed++;
      total++;
      if (mem_ready !== exp_rdy || mem_rdata !== (exp_rdy ? exp_rd : 32'h0))
        $display("FAIL %s_resp c%0d: ready=%b rdata=%h want %b/%h", name, k, mem_ready, mem_rdata,
                 exp_rdy, exp_rdy ? exp_rd : 32'h0);
      else passed++;
      total++;
      if (s_mem_addr !== addr || s_mem_wdata !== wd || s_mem_wstrb !== ws || err_pulse !== 1'b0)
        $display("FAIL %s_bcast c%0d: addr=%h wdata=%h wstrb=%h errp=%b want %h/%h/%h/0", name, k,
                 s_mem_addr, s_mem_wdata, s_mem_wstrb, err_pulse, addr, wd, ws);
      else passed++;
    end
    @(negedge clk);
    mem_valid = 1'b0; s_mem_ready = 4'b0000;
    #1;
    total++;
    if (s_mem_valid !== 4'b0000 || mem_ready !== 1'b0)
      $display("FAIL %s_done: s_mem_valid=%b mem_ready=%b want 0000/0", name, s_mem_valid, mem_ready);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_valid = 1'b1; mem_addr = 32'h0000_0010;
    mem_wdata = 32'h55; mem_wstrb = 4'hF; s_mem_ready = 4'b1111;
    s_mem_rdata = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h1234_5678};
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (mem_ready !== 1'b0 || mem_rdata !== 32'h0 || s_mem_valid !== 4'b0000 || err_pulse !== 1'b0)
      $display("FAIL reset_ctrl: ready=%b rdata=%h sv=%b errp=%b want all 0", mem_ready, mem_rdata, s_mem_valid, err_pulse);
    else passed++;
    total++;
    if (err_cnt !== 16'h0 || err_code !== 2'b00 || err_addr !== 32'h0 || s_mem_addr !== 32'h0 || s_mem_wdata !== 32'h0 || s_mem_wstrb !== 4'h0)
      $display("FAIL reset_regs: cnt=%h code=%b eaddr=%h saddr=%h swd=%h sws=%h want all 0",
               err_cnt, err_code, err_addr, s_mem_addr, s_mem_wdata, s_mem_wstrb);
    else passed++;
    @(negedge clk);
    mem_valid = 1'b0; s_mem_ready = 4'b0000; rst_n = 1'b1;
  endtask

  task automatic test_read();
    run_mapped("read_s0", 32'h0000_0010, 32'h0, 4'h0, 3, 4'b0001, 32'h1234_5678);
  endtask

  task automatic test_write();
    // Region 9 is owned by slaves 1 and 3; slave 1 is the lower index.
    run_mapped("write_r9", 32'h9000_0000, 32'h0000_0041, 4'hF, 1, 4'b0010, 32'h1111_0001);
    run_mapped("write_r8", 32'h8000_0004, 32'h0000_0041, 4'hF, 2, 4'b1000, 32'h3333_0003);
    run_mapped("read_r3",  32'h3000_0008, 32'h0,        4'h0, 1, 4'b0100, 32'h2222_0002);
  endtask

  task automatic test_unmapped();
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 32'h5000_0000; mem_wstrb = 4'h0;
    #1;
    total++;
    if (mem_ready !== 1'b0) $display("FAIL unmapped_c1: ready=%b want 0", mem_ready);
    else passed++;
    @(negedge clk); #1;
    total++;
    if (mem_ready !== 1'b1 || mem_rdata !== 32'hDEADBEEF || err_pulse !== 1'b1 || s_mem_valid !== 4'b0000)
      $display("FAIL unmapped_c2: ready=%b rdata=%h errp=%b sv=%b want 1/deadbeef/1/0000",
               mem_ready, mem_rdata, err_pulse, s_mem_valid);
    else passed++;
    @(negedge clk);
    mem_valid = 1'b0;
    #1;
    total++;
    if (err_code !== 2'b01 || err_addr !== 32'h5000_0000 || err_cnt !== 16'd1 || err_pulse !== 1'b0 || mem_ready !== 1'b0)
      $display("FAIL unmapped_status: code=%b eaddr=%h cnt=%0d errp=%b ready=%b want 01/50000000/1/0/0",
               err_code, err_addr, err_cnt, err_pulse, mem_ready);
    else passed++;
  endtask

  task automatic test_timeout();
    int bad_valid = 0;
    int bad_ready = 0;
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 32'h3000_0004; mem_wstrb = 4'h0; s_mem_ready = 4'b0000;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk); #1;
      if (s_mem_valid !== 4'b0100) bad_valid++;
      if (mem_ready !== 1'b0) bad_ready++;
    end
    total++;
    if (bad_valid != 0 || bad_ready != 0)
      $display("FAIL timeout_busy: cycles with wrong valid=%0d wrong ready=%0d want 0/0", bad_valid, bad_ready);
    else passed++;
    @(negedge clk); #1;
    total++;
    if (s_mem_valid !== 4'b0000 || mem_ready !== 1'b1 || mem_rdata !== 32'hDEADBEEF || err_pulse !== 1'b1)
      $display("FAIL timeout_err: sv=%b ready=%b rdata=%h errp=%b want 0000/1/deadbeef/1",
               s_mem_valid, mem_ready, mem_rdata, err_pulse);
    else passed++;
    @(negedge clk);
    mem_valid = 1'b0;
    #1;
    total++;
    if (err_code !== 2'b10 || err_addr !== 32'h3000_0004 || err_cnt !== 16'd2)
      $display("FAIL timeout_status: code=%b eaddr=%h cnt=%0d want 10/30000004/2", err_code, err_addr, err_cnt);
    else passed++;
  endtask

  task automatic test_overlap_stray();
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 32'h0000_0100; mem_wstrb = 4'h0; s_mem_ready = 4'b0000;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      s_mem_ready = 4'b0010;
      if (k == 2) mem_addr = 32'h3000_0000;
      #1;
      total++;
      if (s_mem_valid !== 4'b0001 || mem_ready !== 1'b0 || mem_rdata !== 32'h0)
        $display("FAIL overlap_stray c%0d: sv=%b ready=%b rdata=%h want 0001/0/0", k, s_mem_valid, mem_ready, mem_rdata);
      else passed++;
    end
    total++;
    if (s_mem_addr !== 32'h3000_0000)
      $display("FAIL overlap_bcast: s_mem_addr=%h want 30000000", s_mem_addr);
    else passed++;
    @(negedge clk);
    s_mem_ready = 4'b0011;
    #1;
    total++;
    if (mem_ready !== 1'b1 || mem_rdata !== 32'h1234_5678)
      $display("FAIL overlap_resp: ready=%b rdata=%h want 1/12345678", mem_ready, mem_rdata);
    else passed++;
    @(negedge clk);
    mem_valid = 1'b0; s_mem_ready = 4'b0000;
  endtask

  task automatic test_abort();
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 32'h3000_0000; mem_wstrb = 4'h0; s_mem_ready = 4'b0000;
    @(negedge clk); #1;
    total++;
    if (s_mem_valid !== 4'b0100) $display("FAIL abort_busy: sv=%b want 0100", s_mem_valid);
    else passed++;
    @(negedge clk);
    mem_valid = 1'b0;
    #1;
    total++;
    if (s_mem_valid !== 4'b0000 || mem_ready !== 1'b0)
      $display("FAIL abort_drop: sv=%b ready=%b want 0000/0", s_mem_valid, mem_ready);
    else passed++;
    @(negedge clk); #1;
    total++;
    if (err_pulse !== 1'b0 || mem_ready !== 1'b0 || err_cnt !== 16'd2)
      $display("FAIL abort_noerr: errp=%b ready=%b cnt=%0d want 0/0/2", err_pulse, mem_ready, err_cnt);
    else passed++;
    run_mapped("after_abort", 32'h3000_0010, 32'h0, 4'h0, 1, 4'b0100, 32'h2222_0002);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 32'h8000_0000; mem_wstrb = 4'h0; s_mem_ready = 4'b0000;
    @(negedge clk);
    s_mem_ready = 4'b1000;
    #1;
    total++;
    if (mem_ready !== 1'b1 || mem_rdata !== 32'h3333_0003)
      $display("FAIL b2b_first: ready=%b rdata=%h want 1/33330003", mem_ready, mem_rdata);
    else passed++;
    @(negedge clk);
    mem_addr = 32'h6000_0000; s_mem_ready = 4'b0000;
    #1;
    total++;
    if (mem_ready !== 1'b0 || s_mem_valid !== 4'b0000)
      $display("FAIL b2b_idle: ready=%b sv=%b want 0/0000", mem_ready, s_mem_valid);
    else passed++;
    @(negedge clk); #1;
    total++;
    if (mem_ready !== 1'b1 || mem_rdata !== 32'hDEADBEEF || err_pulse !== 1'b1)
      $display("FAIL b2b_err: ready=%b rdata=%h errp=%b want 1/deadbeef/1", mem_ready, mem_rdata, err_pulse);
    else passed++;
    @(negedge clk);
    mem_valid = 1'b0;
    #1;
    total++;
    if (err_cnt !== 16'd3 || err_code !== 2'b01 || err_addr !== 32'h6000_0000)
      $display("FAIL b2b_status: cnt=%0d code=%b eaddr=%h want 3/01/60000000", err_cnt, err_code, err_addr);
    else passed++;
  endtask

  task automatic test_reset_mid_busy();
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 32'h0000_0010; mem_wstrb = 4'h0; s_mem_ready = 4'b0000;
    @(negedge clk); #1;
    total++;
    if (s_mem_valid !== 4'b0001) $display("FAIL rstbusy_pre: sv=%b want 0001", s_mem_valid);
    else passed++;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (s_mem_valid !== 4'b0000 || mem_ready !== 1'b0 || err_cnt !== 16'h0 || err_code !== 2'b00 ||
        err_addr !== 32'h0 || s_mem_addr !== 32'h0)
      $display("FAIL rstbusy_clear: sv=%b ready=%b cnt=%0d code=%b eaddr=%h saddr=%h want all 0",
               s_mem_valid, mem_ready, err_cnt, err_code, err_addr, s_mem_addr);
    else passed++;
    @(negedge clk);
    mem_valid = 1'b0; rst_n = 1'b1;
    run_mapped("fresh", 32'h0000_0020, 32'h0, 4'h0, 2, 4'b0001, 32'h1234_5678);
    total++;
    if (err_cnt !== 16'h0) $display("FAIL fresh_cnt: cnt=%0d want 0", err_cnt);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_unmapped();
    test_timeout();
    test_overlap_stray();
    test_abort();
    test_back_to_back();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
